sign_extend_arbiter: RTL and testbench

Shares one registered sign/zero-extension datapath among NUM_REQ requesters using round-robin arbitration. Each requester offers an INPUT_WIDTH sample with a valid/ready handshake and a per-request signed flag. The winner's sample is extended to OUTPUT_WIDTH and presented on a single valid/ready output port tagged with the source ID. The block sits between the narrow-sample producers and the wide arithmetic pipeline.

---
 rtl/sign_extend_arbiter.sv | 116 +++++++++++
 tb/tb_sign_extend_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sign_extend_arbiter.sv
// Round-robin arbiter feeding one registered sign/zero-extension stage.
// Requesters offer narrow samples; the winner is widened and tagged with its index.

module sign_extend_lane #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic [INPUT_WIDTH-1:0]  sample,
  input  logic                    sign,
  output logic [OUTPUT_WIDTH-1:0] ext
);
  generate
    if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_wide
      assign ext = {{(OUTPUT_WIDTH-INPUT_WIDTH){sign & sample[INPUT_WIDTH-1]}}, sample};
    end else begin : g_same
      assign ext = sample;
    end
  endgenerate
endmodule

module sign_extend_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ID_WIDTH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_signed,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUT_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]            out_id
);
  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [OUTPUT_WIDTH-1:0] data;
  } result_t;

  state_t                               state, state_next;
  logic [NUM_REQ-1:0][OUTPUT_WIDTH-1:0] ext;
  logic [ID_WIDTH-1:0]                  ptr, win, idx;
  logic                                 any, load, fire;
  result_t                              res;

  // Every requester gets its own extender so the mux selects finished words.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sign_extend_lane #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_lane (
      .sample(req_data[i*INPUT_WIDTH +: INPUT_WIDTH]),
      .sign  (req_signed[i]),
      .ext   (ext[i])
    );
  end

  // Rotating priority search starting at ptr.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  assign load = (state == EMPTY) | (out_ready & out_valid);
  assign fire = load & any & ~rst;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[win] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    if (fire)                                state_next = FULL;
    else if (out_ready && (state == FULL))   state_next = EMPTY;
  end

  // Outputs
  always_comb begin
    out_valid = (state == FULL);
    out_data  = res.data;
    out_id    = res.id;
  end

  // Result register and pointer only move on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
      ptr <= '0;
    end else if (fire) begin
      res.data <= ext[win];
      res.id   <= win;
      ptr      <= (win == ID_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end
  end
endmodule

// File: tb/tb_sign_extend_arbiter.sv
// Directed bench for sign_extend_arbiter with a behavioural model checked every cycle.
module tb_sign_extend_arbiter;
  localparam int N = 4;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, req_signed;
  logic [31:0] req_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_id;

  int errors = 0;
  int checks = 0;

  sign_extend_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_signed(req_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: the pending result, and which requester is next in line.
  int          m_ptr;
  logic        m_vld;
  logic [15:0] m_data;
  int          m_id;

  function automatic int pick(input logic [3:0] v, input int p);
    logic [1:0] j;
    for (int k = 0; k < N; k++) begin
      j = 2'((p + k) % N);
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  function automatic logic [15:0] widen(input logic [7:0] s, input logic sg);
    int val;
    val = int'(s);
    if (sg && val >= 128) val = val - 256;
    return 16'(val);
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = pick(req_valid, m_ptr);
    if (rst || w < 0 || !(!m_vld || out_ready)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_ptr = 0; m_vld = 1'b0; m_data = 16'h0; m_id = 0;
    end else begin
      w = pick(req_valid, m_ptr);
      if ((!m_vld || out_ready) && w >= 0) begin
        m_data = widen(req_data[w*8 +: 8], req_signed[w]);
        m_id   = w;
        m_vld  = 1'b1;
        m_ptr  = (w + 1) % N;
      end else if (out_ready && m_vld) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_req_ready", 32'(req_ready), 32'(exp_ready()));
      chk("model_out_valid", 32'(out_valid), 32'(m_vld));
      chk("model_out_data",  32'(out_data),  32'(m_data));
      chk("model_out_id",    32'(out_id),    32'(m_id));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [7:0] s, input logic sg);
    req_data[i*8 +: 8] = s;
    req_signed[i]      = sg;
  endtask

  initial begin
    int ids[6];
    int alt[4];
    ids = '{0, 1, 2, 3, 0, 1};
    alt = '{1, 3, 1, 3};
    rst = 1'b1; req_valid = '0; req_signed = '0; req_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_data",  32'(out_data),  0);
    chk("reset_id",    32'(out_id),    0);
    chk("reset_ready", 32'(req_ready), 0);
    repeat (10) step();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_data",  32'(out_data),  0);

    // Single requester: signed, unsigned, positive signed
    out_ready = 1'b1;
    set_slot(1, 8'h80, 1'b1);
    req_valid = 4'b0010;
    #1 chk("single_ready", 32'(req_ready), 32'h2);
    step();
    chk("single_s_valid", 32'(out_valid), 1);
    chk("single_s_data",  32'(out_data),  32'hFF80);
    chk("single_s_id",    32'(out_id),    1);
    set_slot(1, 8'h80, 1'b0);
    #1 chk("single_u_ready", 32'(req_ready), 32'h2);
    step();
    chk("single_u_data", 32'(out_data), 32'h0080);
    set_slot(1, 8'h7F, 1'b1);
    step();
    chk("single_p_data", 32'(out_data), 32'h007F);
    req_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 0);

    // Grant 3 first so the pointer sits at 0, then all four valid
    set_slot(0, 8'h81, 1'b1);
    set_slot(1, 8'h92, 1'b0);
    set_slot(2, 8'h33, 1'b1);
    set_slot(3, 8'hF0, 1'b1);
    req_valid = 4'b1000;
    #1 chk("pre_rr_ready", 32'(req_ready), 32'h8);
    step();
    chk("pre_rr_data", 32'(out_data), 32'hFFF0);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_id",    32'(out_id),    32'(ids[i]));
      chk("rr_valid", 32'(out_valid), 1);
    end
    chk("rr_last_data", 32'(out_data), 32'h0092);

    // Backpressure with 2 and 3 waiting
    out_ready = 1'b0;
    req_valid = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(req_ready), 0);
      step();
      chk("bp_id",   32'(out_id),   1);
      chk("bp_data", 32'(out_data), 32'h0092);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h4);
    step();
    chk("bp_release_id",    32'(out_id),    2);
    chk("bp_release_data",  32'(out_data),  32'h0033);
    chk("bp_release_valid", 32'(out_valid), 1);
    req_valid = 4'b0000;
    step();
    chk("bp_drain_valid", 32'(out_valid), 0);

    // Wrap and skip: last grant 3, then only 1 and 3 valid
    req_valid = 4'b1000;
    step();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("skip_ready_mask", 32'(req_ready & 4'b0101), 0);
      step();
      chk("skip_id", 32'(out_id), 32'(alt[i]));
    end
    req_valid = 4'b0000;
    step();

    // Reset in the middle of a cycle with a result pending and ptr=2
    req_valid = 4'b0010;
    step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_ready",       32'(req_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    chk("post_rst_id",   32'(out_id),   0);
    chk("post_rst_data", 32'(out_data), 32'hFF81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
